// File: rtl/dram_bank_responder.sv
// DRAM bank responder: tracks per-bank row state and refresh, enforces tRCD/tRP/tRFC
// windows, and answers each command with a column strobe or an error pulse/code.
module dram_bank_responder #(
    parameter int NUMBER_OF_BANKS = 8,
    parameter int NUMBER_OF_ROWS  = 128,
    parameter int NUMBER_OF_COLS  = 8,
    parameter int T_RCD           = 2,
    parameter int T_RP            = 2,
    parameter int T_RFC           = 4
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic                               cmd_val,
    input  logic [1:0]                         cmd,
    input  logic [$clog2(NUMBER_OF_BANKS)-1:0] bank_id,
    input  logic [$clog2(NUMBER_OF_ROWS)-1:0]  row_id,
    input  logic [$clog2(NUMBER_OF_COLS)-1:0]  col_id,
    output logic [NUMBER_OF_BANKS-1:0]         bank_open,
    output logic                               busy,
    output logic                               col_strobe,
    output logic [$clog2(NUMBER_OF_BANKS)-1:0] col_bank,
    output logic [$clog2(NUMBER_OF_ROWS)-1:0]  col_row,
    output logic [$clog2(NUMBER_OF_COLS)-1:0]  col_col,
    output logic                               err,
    output logic [2:0]                         err_code,
    output logic [7:0]                         err_count
);
    localparam int NB   = NUMBER_OF_BANKS;
    localparam int BW   = $clog2(NUMBER_OF_BANKS);
    localparam int RW   = $clog2(NUMBER_OF_ROWS);
    localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(T_RFC + 1);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_COL = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ACTIVATING  = 2'd1,
        ST_ACTIVE      = 2'd2,
        ST_PRECHARGING = 2'd3
    } bank_state_t;

    bank_state_t    st_r   [NB];
    bank_state_t    st_s   [NB];
    logic [TW-1:0]  cnt_r  [NB];
    logic [TW-1:0]  cnt_s  [NB];
    logic [RW-1:0]  row_r  [NB];
    logic [RW-1:0]  row_s  [NB];
    logic           ref_busy_r, ref_busy_s;
    logic [FW-1:0]  ref_cnt_r, ref_cnt_s;
    logic [NB-1:0]  eff_idle_s, eff_active_s, open_s;
    logic           busy_s, strobe_s, err_s;
    logic [2:0]     code_s;

    // Bank timers tick every edge; at most one command then overrides its target bank.
    always_comb begin
        strobe_s   = 1'b0;
        err_s      = 1'b0;
        code_s     = 3'd0;
        ref_busy_s = ref_busy_r;
        ref_cnt_s  = ref_cnt_r;
        busy_s     = 1'b0;
        for (int i = 0; i < NB; i++) begin
            st_s[i]  = st_r[i];
            cnt_s[i] = cnt_r[i];
            row_s[i] = row_r[i];
            eff_idle_s[i]   = (st_r[i] == ST_IDLE) ||
                              (st_r[i] == ST_PRECHARGING && cnt_r[i] == TW'(0));
            eff_active_s[i] = (st_r[i] == ST_ACTIVE) ||
                              (st_r[i] == ST_ACTIVATING && cnt_r[i] == TW'(0));
            case (st_r[i])
                ST_ACTIVATING: begin
                    if (cnt_r[i] == TW'(0)) st_s[i] = ST_ACTIVE;
                    else                    cnt_s[i] = cnt_r[i] - TW'(1);
                end
                ST_PRECHARGING: begin
                    if (cnt_r[i] == TW'(0)) st_s[i] = ST_IDLE;
                    else                    cnt_s[i] = cnt_r[i] - TW'(1);
                end
                default: ;
            endcase
        end
        if (ref_busy_r) begin
            if (ref_cnt_r == FW'(0)) ref_busy_s = 1'b0;
            else                     ref_cnt_s  = ref_cnt_r - FW'(1);
        end else begin
            ref_cnt_s = ref_cnt_r;
        end

        if (!cmd_val) begin
            strobe_s = 1'b0;
        end else if (ref_busy_r && ref_cnt_r != FW'(0)) begin
            err_s  = 1'b1;
            code_s = 3'd6;
        end else begin
            case (cmd)
                CMD_ACT: begin
                    if (eff_idle_s[bank_id]) begin
                        st_s[bank_id]  = ST_ACTIVATING;
                        cnt_s[bank_id] = TW'(T_RCD - 1);
                        row_s[bank_id] = row_id;
                    end else begin
                        err_s  = 1'b1;
                        code_s = 3'd1;
                    end
                end
                CMD_COL: begin
                    if (!eff_active_s[bank_id]) begin
                        err_s  = 1'b1;
                        code_s = 3'd2;
                    end else if (row_id != row_r[bank_id]) begin
                        err_s  = 1'b1;
                        code_s = 3'd3;
                    end else begin
                        strobe_s = 1'b1;
                    end
                end
                CMD_REF: begin
                    if (&eff_idle_s) begin
                        ref_busy_s = 1'b1;
                        ref_cnt_s  = FW'(T_RFC - 1);
                    end else begin
                        err_s  = 1'b1;
                        code_s = 3'd5;
                    end
                end
                CMD_PRE: begin
                    if (eff_active_s[bank_id]) begin
                        st_s[bank_id]  = ST_PRECHARGING;
                        cnt_s[bank_id] = TW'(T_RP - 1);
                    end else if (!eff_idle_s[bank_id]) begin
                        err_s  = 1'b1;
                        code_s = 3'd4;
                    end else begin
                        err_s = 1'b0;
                    end
                end
                default: err_s = 1'b0;
            endcase
        end

        busy_s = ref_busy_s;
        for (int i = 0; i < NB; i++) begin
            open_s[i] = (st_s[i] == ST_ACTIVE);
            if (st_s[i] == ST_ACTIVATING || st_s[i] == ST_PRECHARGING) busy_s = 1'b1;
            else                                                       busy_s = busy_s;
        end
    end

    // State and registered outputs; error bookkeeping holds the last cause and saturates.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            for (int i = 0; i < NB; i++) begin
                st_r[i]  <= ST_IDLE;
                cnt_r[i] <= TW'(0);
                row_r[i] <= RW'(0);
            end
            ref_busy_r <= 1'b0;
            ref_cnt_r  <= FW'(0);
            bank_open  <= {NB{1'b0}};
            busy       <= 1'b0;
            col_strobe <= 1'b0;
            col_bank   <= BW'(0);
            col_row    <= RW'(0);
            col_col    <= '0;
            err        <= 1'b0;
            err_code   <= 3'd0;
            err_count  <= 8'd0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                st_r[i]  <= st_s[i];
                cnt_r[i] <= cnt_s[i];
                row_r[i] <= row_s[i];
            end
            ref_busy_r <= ref_busy_s;
            ref_cnt_r  <= ref_cnt_s;
            bank_open  <= open_s;
            busy       <= busy_s;
            col_strobe <= strobe_s;
            err        <= err_s;
            if (strobe_s) begin
                col_bank <= bank_id;
                col_row  <= row_id;
                col_col  <= col_id;
            end
            if (err_s) begin
                err_code <= code_s;
                if (err_count != 8'd255) err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_dram_bank_responder.sv
// Self-checking bench for dram_bank_responder: table of hand-derived vectors fed through
// a scoreboard queue, plus saturation, refresh-busy and mid-activate reset sequences.
module tb_dram_bank_responder;
    localparam logic [1:0] ACT = 2'b00, COL = 2'b01, REF = 2'b10, PRE = 2'b11;

    typedef struct {
        logic       val;
        logic [1:0] cmd;
        logic [2:0] bank;
        logic [6:0] row;
        logic [2:0] col;
        logic       strobe;
        logic       err;
        logic [2:0] code;
        logic [7:0] open;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       cmd_val;
    logic [1:0] cmd;
    logic [2:0] bank_id;
    logic [6:0] row_id;
    logic [2:0] col_id;
    logic [7:0] bank_open;
    logic       busy, col_strobe, err;
    logic [2:0] col_bank, col_col, err_code;
    logic [6:0] col_row;
    logic [7:0] err_count;

    int   tests = 0;
    int   failed = 0;
    int   exp_cnt = 0;
    vec_t tbl[$];
    vec_t sb[$];

    dram_bank_responder dut (
        .clk(clk), .rst_b(rst_b), .cmd_val(cmd_val), .cmd(cmd), .bank_id(bank_id),
        .row_id(row_id), .col_id(col_id), .bank_open(bank_open), .busy(busy),
        .col_strobe(col_strobe), .col_bank(col_bank), .col_row(col_row), .col_col(col_col),
        .err(err), .err_code(err_code), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [1:0] c, input int b, input int r,
                                input int cl, input logic s, input logic e, input int code,
                                input int op, input logic bz);
        vec_t t;
        t.val = v; t.cmd = c; t.bank = 3'(b); t.row = 7'(r); t.col = 3'(cl);
        t.strobe = s; t.err = e; t.code = 3'(code); t.open = 8'(op); t.busy = bz;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        cmd_val = v.val; cmd = v.cmd; bank_id = v.bank; row_id = v.row; col_id = v.col;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.err && exp_cnt < 255) exp_cnt++;
        chk("col_strobe", 32'(col_strobe), 32'(e.strobe));
        chk("err", 32'(err), 32'(e.err));
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("bank_open", 32'(bank_open), 32'(e.open));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("err_count", 32'(err_count), 32'(exp_cnt));
        if (e.strobe) begin
            chk("col_bank", 32'(col_bank), 32'(e.bank));
            chk("col_row", 32'(col_row), 32'(e.row));
            chk("col_col", 32'(col_col), 32'(e.col));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_open"}, 32'(bank_open), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_strobe"}, 32'(col_strobe), 32'd0);
        chk({tag, "_col"}, 32'({col_bank, col_row, col_col}), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
        chk({tag, "_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        rst_b = 1'b1; cmd_val = 1'b0; cmd = 2'b00; bank_id = 3'd0; row_id = 7'd0; col_id = 3'd0;
        // val cmd bank row col | strobe err code open busy
        tbl.push_back(mk(1, ACT, 3, 17, 0, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, ACT, 0, 0, 0, 0, 0, 0, 8'h00, 1));
        tbl.push_back(mk(1, COL, 3, 17, 5, 1, 0, 0, 8'h08, 0));
        tbl.push_back(mk(0, ACT, 0, 0, 0, 0, 0, 0, 8'h08, 0));
        tbl.push_back(mk(1, ACT, 1, 4, 0, 0, 0, 0, 8'h08, 1));
        tbl.push_back(mk(1, COL, 1, 4, 0, 0, 1, 2, 8'h08, 1));
        tbl.push_back(mk(1, COL, 1, 4, 1, 1, 0, 2, 8'h0A, 0));
        tbl.push_back(mk(1, ACT, 0, 9, 0, 0, 0, 2, 8'h0A, 1));
        tbl.push_back(mk(0, ACT, 0, 0, 0, 0, 0, 2, 8'h0A, 1));
        tbl.push_back(mk(1, COL, 0, 10, 2, 0, 1, 3, 8'h0B, 0));
        tbl.push_back(mk(1, PRE, 0, 0, 0, 0, 0, 3, 8'h0A, 1));
        tbl.push_back(mk(1, ACT, 0, 10, 0, 0, 1, 1, 8'h0A, 1));
        tbl.push_back(mk(1, ACT, 0, 10, 0, 0, 0, 1, 8'h0A, 1));
        tbl.push_back(mk(0, ACT, 0, 0, 0, 0, 0, 1, 8'h0A, 1));
        tbl.push_back(mk(1, COL, 0, 10, 7, 1, 0, 1, 8'h0B, 0));
        tbl.push_back(mk(1, REF, 0, 0, 0, 0, 1, 5, 8'h0B, 0));
        tbl.push_back(mk(1, PRE, 0, 0, 0, 0, 0, 5, 8'h0A, 1));
        tbl.push_back(mk(1, PRE, 1, 0, 0, 0, 0, 5, 8'h08, 1));
        tbl.push_back(mk(1, PRE, 3, 0, 0, 0, 0, 5, 8'h00, 1));
        tbl.push_back(mk(1, PRE, 3, 0, 0, 0, 1, 4, 8'h00, 1));
        tbl.push_back(mk(1, REF, 0, 0, 0, 0, 0, 4, 8'h00, 1));
        tbl.push_back(mk(1, ACT, 2, 1, 0, 0, 1, 6, 8'h00, 1));
        tbl.push_back(mk(0, ACT, 0, 0, 0, 0, 0, 6, 8'h00, 1));
        tbl.push_back(mk(1, ACT, 2, 1, 0, 0, 1, 6, 8'h00, 1));
        tbl.push_back(mk(1, ACT, 2, 1, 0, 0, 0, 6, 8'h00, 1));
        tbl.push_back(mk(0, ACT, 0, 0, 0, 0, 0, 6, 8'h00, 1));
        tbl.push_back(mk(0, ACT, 0, 0, 0, 0, 0, 6, 8'h04, 0));
        tbl.push_back(mk(1, PRE, 4, 0, 0, 0, 0, 6, 8'h04, 0));
        tbl.push_back(mk(1, COL, 2, 1, 3, 1, 0, 6, 8'h04, 0));
        tbl.push_back(mk(1, COL, 2, 1, 4, 1, 0, 6, 8'h04, 0));
        tbl.push_back(mk(0, COL, 2, 1, 5, 0, 0, 6, 8'h04, 0));

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_b = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        chk("col_col_held", 32'(col_col), 32'd4);

        // Illegal COLs to an idle bank drive the error counter into saturation.
        for (int i = 0; i < 300; i++) step(mk(1, COL, 5, 0, 0, 0, 1, 2, 8'h04, 0));
        chk("err_count_sat", 32'(err_count), 32'd255);

        // Reset asserted mid-activate clears everything immediately.
        step(mk(1, ACT, 6, 3, 0, 0, 0, 2, 8'h04, 1));
        @(negedge clk);
        cmd_val = 1'b0;
        rst_b = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst_b = 1'b0;
        exp_cnt = 0;
        step(mk(1, COL, 6, 3, 0, 0, 1, 2, 8'h00, 0));

        // Refresh keeps busy high for exactly T_RFC edges.
        step(mk(1, REF, 0, 0, 0, 0, 0, 2, 8'h00, 1));
        step(mk(0, ACT, 0, 0, 0, 0, 0, 2, 8'h00, 1));
        step(mk(0, ACT, 0, 0, 0, 0, 0, 2, 8'h00, 1));
        step(mk(0, ACT, 0, 0, 0, 0, 0, 2, 8'h00, 1));
        step(mk(0, ACT, 0, 0, 0, 0, 0, 2, 8'h00, 0));
        step(mk(1, REF, 0, 0, 0, 0, 0, 2, 8'h00, 1));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
